tl_ram_responder: RTL and testbench
===================================

Name: tl_ram_responder

Overview:
- Single-beat TileLink-UL manager (responder) terminating the A channel and generating D-channel responses. It is the far end of the client-side A/D path that carries requests through FIFO-fixer and crossbar stages.
- Backs a small flop-based 64-bit-wide memory window. Used as a scratchpad and test target on the peripheral bus.
- Supports one response in flight, with full-throughput pipelining: a new request is accepted in the same cycle the current response is taken.

Parameters:
BASE_ADDR, 32'h0001_0000, byte base address of the window; must be aligned to DEPTH*8
DEPTH, 16, number of 64-bit words; power of two, minimum 2
CNT_W, 8, width of the saturating error counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = in reset)
auto_in_a_ready  output  1  request accepted when high with a_valid
auto_in_a_valid  input  1  request valid
auto_in_a_bits_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get; all other values are unsupported
auto_in_a_bits_size  input  3  log2 bytes; 0..3 legal
auto_in_a_bits_source  input  7  request ID, echoed on D
auto_in_a_bits_address  input  32  byte address
auto_in_a_bits_mask  input  8  byte lanes
auto_in_a_bits_data  input  64  write data
auto_in_d_ready  input  1  response sink ready
auto_in_d_valid  output  1  response valid
auto_in_d_bits_opcode  output  3  0=AccessAck, 1=AccessAckData
auto_in_d_bits_size  output  3  echo of request size
auto_in_d_bits_source  output  7  echo of request source
auto_in_d_bits_denied  output  1  request rejected
auto_in_d_bits_data  output  64  read data; 0 unless a successful Get
auto_in_d_bits_corrupt  output  1  data invalid
error_count  output  CNT_W  saturating count of denied responses

Behaviour:
- Reset (async assert, released synchronously by the integrator):
  - d_valid=0 and all d_bits registers 0.
  - error_count=0.
  - All memory words 0.
  - A response in flight when reset asserts is dropped.
- Handshake:
  - a_ready = !d_valid || d_ready (combinational). This is the only combinational input-to-output path.
  - A fires when a_valid && a_ready. d_valid sets on the clock edge after A fires.
  - On D fire with no A fire, d_valid clears.
  - On A and D firing in the same cycle, d_valid stays 1 and the D registers load the new response. No bubble.
  - d_bits are held stable while d_valid && !d_ready.
- Decode, registered on A fire:
  - hit = address in [BASE_ADDR, BASE_ADDR + DEPTH*8).
  - idx = address[log2(DEPTH)+2:3].
  - aligned = (address & ((1<<size)-1)) == 0.
  - legal = hit && aligned && size<=3 && opcode in {0,1,4}.
- Get:
  - Legal: opcode=1, data = mem[idx] (full 64-bit word, unmasked), denied=0, corrupt=0.
  - Illegal: opcode=1, data=0, denied=1, corrupt=1.
- PutFull/PutPartial:
  - Opcode=0 in both cases.
  - Legal: byte lane i of mem[idx] is written from data lane i where mask[i]=1, at the same edge the response is registered. denied=0.
  - Illegal: no write, denied=1.
  - corrupt=0 in both cases.
- Unsupported opcode (2,3,5,6,7): opcode=0, denied=1, corrupt=0, no write.
- size and source are echoed unchanged for every response, including denied ones.
- Ordering:
  - Responses leave in acceptance order.
  - A Get accepted in the cycle after a Put to the same word returns the new data.
- error_count increments by 1 on every denied response fire (D fire with denied=1). It saturates at 2^CNT_W-1 and does not wrap.
- a_valid can drop without firing; no state changes.

Test Plan:
- Reset state: hold reset=0 for 3 cycles, with a_valid=1 -> d_valid=0, error_count=0. After release, a_ready=1 on the first cycle.
- Write/read: PutFull addr 0x10008, mask 0xFF, data 0x1122334455667788, source 5. Then Get 0x10008, size 3, source 6. Expected responses in order:
  - opcode=0, source=5, denied=0
  - opcode=1, data=0x1122334455667788, source=6
- Partial write: after the write above, PutPartial mask 0x0F data 0xAAAAAAAA_BBBBBBBB, then Get -> data 0x11223344BBBBBBBB.
- Errors:
  - Get 0x20000 -> denied=1, corrupt=1, data=0.
  - Get 0x10004 size 3 (misaligned) -> denied=1.
  - opcode 2 -> opcode=0, denied=1.
  - error_count=3 afterwards.
- Backpressure/throughput:
  - d_ready=0 for 5 cycles with a response pending -> a_ready=0 and d_bits stable.
  - Then d_ready=1 with back-to-back Gets -> one response per cycle, no bubbles.
- Saturation and reset mid-flight:
  - CNT_W=2 with 5 denied requests -> error_count=3.
  - Assert reset while d_valid=1 -> d_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tl_ram_responder.sv
// Single-beat TileLink-UL responder in front of a flop-based 64-bit scratchpad.
// Holds one response at a time and accepts a new request in the cycle the current one drains.
module tl_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          DEPTH     = 16,
  parameter int          CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  output logic             auto_in_a_ready,
  input  logic             auto_in_a_valid,
  input  logic [2:0]       auto_in_a_bits_opcode,
  input  logic [2:0]       auto_in_a_bits_size,
  input  logic [6:0]       auto_in_a_bits_source,
  input  logic [31:0]      auto_in_a_bits_address,
  input  logic [7:0]       auto_in_a_bits_mask,
  input  logic [63:0]      auto_in_a_bits_data,
  input  logic             auto_in_d_ready,
  output logic             auto_in_d_valid,
  output logic [2:0]       auto_in_d_bits_opcode,
  output logic [2:0]       auto_in_d_bits_size,
  output logic [6:0]       auto_in_d_bits_source,
  output logic             auto_in_d_bits_denied,
  output logic [63:0]      auto_in_d_bits_data,
  output logic             auto_in_d_bits_corrupt,
  output logic [CNT_W-1:0] error_count
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;

  logic [63:0]      mem [DEPTH];
  logic             a_fire;
  logic             d_fire;
  logic [IDX_W-1:0] idx;
  logic [2:0]       align_mask;
  logic             hit;
  logic             aligned;
  logic             size_ok;
  logic             op_ok;
  logic             legal;

  logic [2:0]       nxt_opcode;
  logic             nxt_denied;
  logic             nxt_corrupt;
  logic [63:0]      nxt_data;
  logic             do_write;

  assign auto_in_a_ready = !auto_in_d_valid || auto_in_d_ready;
  assign a_fire          = auto_in_a_valid && auto_in_a_ready;
  assign d_fire          = auto_in_d_valid && auto_in_d_ready;

  // Window is aligned to its own size, so the hit test is a compare of the upper address bits.
  assign hit     = (auto_in_a_bits_address[31:IDX_W+3] == BASE_ADDR[31:IDX_W+3]);
  assign idx     = auto_in_a_bits_address[IDX_W+2:3];
  assign size_ok = !auto_in_a_bits_size[2];
  assign aligned = ((auto_in_a_bits_address[2:0] & align_mask) == 3'b000);
  assign op_ok   = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                   (auto_in_a_bits_opcode == OP_PUT_PART) ||
                   (auto_in_a_bits_opcode == OP_GET);
  assign legal   = hit && aligned && size_ok && op_ok;

  always_comb begin
    case (auto_in_a_bits_size)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  always_comb begin
    nxt_opcode  = D_ACK;
    nxt_denied  = 1'b1;
    nxt_corrupt = 1'b0;
    nxt_data    = '0;
    do_write    = 1'b0;
    case (auto_in_a_bits_opcode)
      OP_GET: begin
        nxt_opcode = D_ACK_DATA;
        if (legal) begin
          nxt_denied = 1'b0;
          nxt_data   = mem[idx];
        end else begin
          nxt_corrupt = 1'b1;
        end
      end
      OP_PUT_FULL, OP_PUT_PART: begin
        nxt_denied = !legal;
        do_write   = a_fire && legal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_in_d_valid <= 1'b0;
    end else if (a_fire) begin
      auto_in_d_valid <= 1'b1;
    end else if (d_fire) begin
      auto_in_d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_in_d_bits_opcode  <= '0;
      auto_in_d_bits_size    <= '0;
      auto_in_d_bits_source  <= '0;
      auto_in_d_bits_denied  <= 1'b0;
      auto_in_d_bits_data    <= '0;
      auto_in_d_bits_corrupt <= 1'b0;
    end else if (a_fire) begin
      auto_in_d_bits_opcode  <= nxt_opcode;
      auto_in_d_bits_size    <= auto_in_a_bits_size;
      auto_in_d_bits_source  <= auto_in_a_bits_source;
      auto_in_d_bits_denied  <= nxt_denied;
      auto_in_d_bits_data    <= nxt_data;
      auto_in_d_bits_corrupt <= nxt_corrupt;
    end
  end

  // Write lands on the accept edge, so a Get in the following cycle already sees it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (auto_in_a_bits_mask[b]) begin
          mem[idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_count <= '0;
    end else if (d_fire && auto_in_d_bits_denied && (error_count != {CNT_W{1'b1}})) begin
      error_count <= error_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_tl_ram_responder.sv
// Bench for tl_ram_responder: directed vector table, hand sequences for backpressure
// and reset, then random traffic checked against a queue/array reference model.
module tb_tl_ram_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic [6:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_ready;

  logic        a_ready,  d_valid,  d_denied,  d_corrupt;
  logic [2:0]  d_opcode,  d_size;
  logic [6:0]  d_source;
  logic [63:0] d_data;
  logic [7:0]  err_cnt;

  logic        a_ready2, d_valid2, d_denied2, d_corrupt2;
  logic [2:0]  d_opcode2, d_size2;
  logic [6:0]  d_source2;
  logic [63:0] d_data2;
  logic [1:0]  err_cnt2;

  always #5 clock = ~clock;

  tl_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_size(a_size),
    .auto_in_a_bits_source(a_source), .auto_in_a_bits_address(a_address),
    .auto_in_a_bits_mask(a_mask), .auto_in_a_bits_data(a_data),
    .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
    .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_size(d_size),
    .auto_in_d_bits_source(d_source), .auto_in_d_bits_denied(d_denied),
    .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt),
    .error_count(err_cnt)
  );

  tl_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a_ready2), .auto_in_a_valid(a_valid),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_size(a_size),
    .auto_in_a_bits_source(a_source), .auto_in_a_bits_address(a_address),
    .auto_in_a_bits_mask(a_mask), .auto_in_a_bits_data(a_data),
    .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid2),
    .auto_in_d_bits_opcode(d_opcode2), .auto_in_d_bits_size(d_size2),
    .auto_in_d_bits_source(d_source2), .auto_in_d_bits_denied(d_denied2),
    .auto_in_d_bits_data(d_data2), .auto_in_d_bits_corrupt(d_corrupt2),
    .error_count(err_cnt2)
  );

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [6:0]  source;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [6:0]  src;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [63:0] e_data;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem_m [DEPTH];
  resp_t       q [$];
  int          den_cnt = 0;
  resp_t       obs;
  logic        obs_valid;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [78:0] pack(input resp_t r);
    return {r.opcode, r.size, r.source, r.denied, r.corrupt, r.data};
  endfunction

  // Reference: evaluate one accepted request directly from the access rules.
  task automatic model_access(input logic [2:0] op, input logic [2:0] sz, input logic [6:0] src,
                              input logic [31:0] addr, input logic [7:0] mask,
                              input logic [63:0] data, output resp_t r);
    longint a = longint'(addr);
    bit hit = (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 8);
    bit aligned = (sz <= 3) && ((a % (longint'(1) << sz)) == 0);
    bit legal = hit && aligned && (op == 0 || op == 1 || op == 4);
    int w = int'((a - longint'(BASE)) / 8);
    r.size = sz;
    r.source = src;
    r.denied = !legal;
    r.corrupt = 1'b0;
    r.data = '0;
    r.opcode = 3'd0;
    if (op == 4) begin
      r.opcode = 3'd1;
      if (legal) r.data = mem_m[w];
      else r.corrupt = 1'b1;
    end else if ((op == 0 || op == 1) && legal) begin
      for (int b = 0; b < 8; b++)
        if (mask[b]) mem_m[w][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic model_reset();
    q.delete();
    den_cnt = 0;
    for (int w = 0; w < DEPTH; w++) mem_m[w] = '0;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model, step past the edge.
  task automatic cycle();
    resp_t act, act2, r, dropped;
    bit exp_ready, exp_valid;
    #1;
    exp_valid = (q.size() > 0);
    exp_ready = !exp_valid || d_ready;
    check("a_ready", a_ready, exp_ready);
    check("a_ready2", a_ready2, exp_ready);
    check("d_valid", d_valid, exp_valid);
    check("d_valid2", d_valid2, exp_valid);
    act  = '{d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
    act2 = '{d_opcode2, d_size2, d_source2, d_denied2, d_corrupt2, d_data2};
    obs = act;
    obs_valid = d_valid;
    if (exp_valid) begin
      check("d_bits", pack(act), pack(q[0]));
      check("d_bits2", pack(act2), pack(q[0]));
    end
    check("error_count", err_cnt, (den_cnt > 255) ? 255 : den_cnt);
    check("error_count_sat", err_cnt2, (den_cnt > 3) ? 3 : den_cnt);
    if (exp_valid && d_ready) begin
      dropped = q.pop_front();
      if (dropped.denied) den_cnt++;
    end
    if (a_valid && exp_ready) begin
      model_access(a_opcode, a_size, a_source, a_address, a_mask, a_data, r);
      q.push_back(r);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] sz, input logic [6:0] src,
                       input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
    a_valid = 1'b1;
    a_opcode = op;
    a_size = sz;
    a_source = src;
    a_address = addr;
    a_mask = mask;
    a_data = data;
  endtask

  vec_t vt [15];

  initial begin
    resp_t held;
    vt[0]  = '{3'd0, 3'd3, 7'd5,  32'h0001_0008, 8'hFF, 64'h1122334455667788, 3'd0, 1'b0, 1'b0, 64'h0};
    vt[1]  = '{3'd4, 3'd3, 7'd6,  32'h0001_0008, 8'h00, 64'h0, 3'd1, 1'b0, 1'b0, 64'h1122334455667788};
    vt[2]  = '{3'd1, 3'd3, 7'd7,  32'h0001_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 3'd0, 1'b0, 1'b0, 64'h0};
    vt[3]  = '{3'd4, 3'd3, 7'd8,  32'h0001_0008, 8'h00, 64'h0, 3'd1, 1'b0, 1'b0, 64'h11223344_BBBBBBBB};
    vt[4]  = '{3'd4, 3'd3, 7'd9,  32'h0002_0000, 8'h00, 64'h0, 3'd1, 1'b1, 1'b1, 64'h0};
    vt[5]  = '{3'd4, 3'd3, 7'd10, 32'h0001_0004, 8'h00, 64'h0, 3'd1, 1'b1, 1'b1, 64'h0};
    vt[6]  = '{3'd2, 3'd3, 7'd11, 32'h0001_0008, 8'hFF, 64'h0, 3'd0, 1'b1, 1'b0, 64'h0};
    vt[7]  = '{3'd4, 3'd3, 7'd12, 32'h0001_0078, 8'h00, 64'h0, 3'd1, 1'b0, 1'b0, 64'h0};
    vt[8]  = '{3'd4, 3'd3, 7'd13, 32'h0001_0080, 8'h00, 64'h0, 3'd1, 1'b1, 1'b1, 64'h0};
    vt[9]  = '{3'd1, 3'd2, 7'd14, 32'h0001_000C, 8'hF0, 64'hCCCCCCCC_00000000, 3'd0, 1'b0, 1'b0, 64'h0};
    vt[10] = '{3'd4, 3'd0, 7'd15, 32'h0001_000B, 8'h00, 64'h0, 3'd1, 1'b0, 1'b0, 64'hCCCCCCCC_BBBBBBBB};
    vt[11] = '{3'd4, 3'd4, 7'd16, 32'h0001_0000, 8'h00, 64'h0, 3'd1, 1'b1, 1'b1, 64'h0};
    vt[12] = '{3'd7, 3'd0, 7'd17, 32'h0001_0000, 8'hFF, 64'h1, 3'd0, 1'b1, 1'b0, 64'h0};
    vt[13] = '{3'd4, 3'd3, 7'd18, 32'h0001_0000, 8'h00, 64'h0, 3'd1, 1'b0, 1'b0, 64'h0};
    vt[14] = '{3'd0, 3'd3, 7'd19, 32'h0002_0000, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b1, 1'b0, 64'h0};

    model_reset();
    reset = 1'b1;
    d_ready = 1'b1;
    drive(3'd4, 3'd3, 7'd1, 32'h0001_0000, 8'h00, 64'h0);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset_d_valid", d_valid, 1'b0);
      check("reset_error_count", err_cnt, 8'd0);
    end
    reset = 1'b1;
    a_valid = 1'b0;
    #1 check("a_ready_after_reset", a_ready, 1'b1);

    // Directed vectors, one request at a time.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].op, vt[i].size, vt[i].src, vt[i].addr, vt[i].mask, vt[i].data);
      d_ready = 1'b1;
      cycle();
      a_valid = 1'b0;
      cycle();
      check("vec_valid", obs_valid, 1'b1);
      check($sformatf("vec%0d", i), pack(obs),
            {vt[i].e_op, vt[i].size, vt[i].src, vt[i].e_den, vt[i].e_cor, vt[i].e_data});
      if (i == 6) check("error_count_after_3", err_cnt, 8'd3);
    end
    cycle();
    check("error_count_7", err_cnt, 8'd7);
    check("error_count_sat_3", err_cnt2, 2'd3);

    // Backpressure: response held, A blocked, bits stable.
    drive(3'd4, 3'd3, 7'd20, 32'h0001_0008, 8'h00, 64'h0);
    cycle();
    drive(3'd4, 3'd3, 7'd21, 32'h0001_0000, 8'h00, 64'h0);
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) held = obs;
      check("bp_a_ready", a_ready, 1'b0);
      check("bp_stable", pack(obs), pack(held));
    end
    check("bp_source", obs.source, 7'd20);

    // Back-to-back, Put then Gets to the same word with no idle cycles.
    d_ready = 1'b1;
    drive(3'd0, 3'd3, 7'd30, 32'h0001_0010, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    cycle();
    check("b2b_valid_0", obs_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(3'd4, 3'd3, 7'(31 + i), 32'h0001_0010, 8'h00, 64'h0);
      cycle();
      check("b2b_valid", obs_valid, 1'b1);
      if (i == 1) check("b2b_get_after_put", obs.data, 64'hDEADBEEF_CAFEF00D);
    end
    a_valid = 1'b0;
    cycle();
    check("b2b_last_source", obs.source, 7'd34);
    cycle();

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] op, sz;
      int idx, off;
      logic [31:0] addr;
      int pick = $urandom_range(0, 7);
      op = (pick < 2) ? 3'd0 : (pick < 3) ? 3'd1 : (pick < 6) ? 3'd4 : 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      idx = $urandom_range(0, DEPTH - 1);
      off = $urandom_range(0, 7);
      if (sz <= 3 && $urandom_range(0, 4) != 0) off = off - (off % (1 << sz));
      addr = BASE + 32'(idx * 8 + off);
      case ($urandom_range(0, 19))
        0: addr = addr + 32'(DEPTH * 8);
        1: addr = addr - 32'(DEPTH * 8);
        default: ;
      endcase
      drive(op, sz, 7'($urandom), addr, 8'($urandom), {$urandom, $urandom});
      a_valid = ($urandom_range(0, 2) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    a_valid = 1'b0;
    d_ready = 1'b1;
    cycle();
    cycle();

    // Reset while a response is pending.
    drive(3'd4, 3'd3, 7'd40, 32'h0001_0010, 8'h00, 64'h0);
    d_ready = 1'b0;
    cycle();
    a_valid = 1'b0;
    check("pre_reset_valid", d_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_valid", d_valid, 1'b0);
    check("async_reset_count", err_cnt, 8'd0);
    check("async_reset_data", d_data, 64'h0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    d_ready = 1'b1;
    drive(3'd4, 3'd3, 7'd41, 32'h0001_0010, 8'h00, 64'h0);
    cycle();
    a_valid = 1'b0;
    cycle();
    check("post_reset_mem", pack(obs), {3'd1, 3'd3, 7'd41, 1'b0, 1'b0, 64'h0});
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
